fetch_stage: RTL and testbench



---
 rtl/cpu_pkg.sv | 26 ++
 rtl/fetch_stage_if.sv | 45 ++++
 rtl/pc_select.sv | 28 ++
 rtl/fetch_stage.sv | 89 ++++++++
 tb/tb_fetch_stage.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset/trap vector defaults, IF_ID field layout and the
// next-PC select encoding used by the fetch stage.
package cpu_pkg;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h8000_0000;
    localparam logic [31:0] DEF_IRQ_VECTOR   = 32'h8000_0004;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0008;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int INSTR_LSB = 0;
    localparam int INSTR_MSB = 31;
    localparam int PC4_LSB   = 32;
    localparam int PC4_MSB   = 63;

    typedef enum logic [2:0] {
        SEL_IRQ,
        SEL_EXC,
        SEL_HOLD,
        SEL_JR,
        SEL_J,
        SEL_BR,
        SEL_SEQ
    } npc_sel_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: ID redirect/stall controls, instruction memory port and IF_ID.
// With FETCH_PERF_CNT_EN defined the bus also carries fetch_count/flush_count.
interface fetch_stage_if;

    logic        PC_IF_ID_Write;
    logic        Z;
    logic        J;
    logic        JR;
    logic        interrupt;
    logic        exception;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] jr_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] PC;
    logic [63:0] IF_ID;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] flush_count;

    modport master (
        input  PC_IF_ID_Write, Z, J, JR, interrupt, exception,
        input  branch_target, jump_target, jr_target, imem_rdata,
        output imem_addr, PC, IF_ID, fetch_count, flush_count
    );
    modport slave (
        output PC_IF_ID_Write, Z, J, JR, interrupt, exception,
        output branch_target, jump_target, jr_target, imem_rdata,
        input  imem_addr, PC, IF_ID, fetch_count, flush_count
    );
`else
    modport master (
        input  PC_IF_ID_Write, Z, J, JR, interrupt, exception,
        input  branch_target, jump_target, jr_target, imem_rdata,
        output imem_addr, PC, IF_ID
    );
    modport slave (
        output PC_IF_ID_Write, Z, J, JR, interrupt, exception,
        output branch_target, jump_target, jr_target, imem_rdata,
        input  imem_addr, PC, IF_ID
    );
`endif

endinterface

// File: rtl/pc_select.sv
// Next-PC source priority encoder. Traps outrank the stall; the stall outranks
// JR/J/Z because their operands may still be waiting on load data.
module pc_select
    import cpu_pkg::*;
(
    input  logic     pc_if_id_write,
    input  logic     z,
    input  logic     j,
    input  logic     jr,
    input  logic     interrupt,
    input  logic     exception,
    output npc_sel_e sel,
    output logic     flush
);

    always_comb begin
        sel   = SEL_SEQ;
        flush = 1'b1;
        if (interrupt)            sel = SEL_IRQ;
        else if (exception)       sel = SEL_EXC;
        else if (!pc_if_id_write) sel = SEL_HOLD;
        else if (jr)              sel = SEL_JR;
        else if (j)               sel = SEL_J;
        else if (z)               sel = SEL_BR;
        if (sel == SEL_HOLD || sel == SEL_SEQ) flush = 1'b0;
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC mux and IF_ID pipeline register.
// Optional FETCH_PERF_CNT_EN adds wrapping fetch/flush event counters.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [31:0] IRQ_VECTOR   = DEF_IRQ_VECTOR,
    parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
    input logic          clk,
    input logic          rst_n,
    fetch_stage_if.master bus
);

    npc_sel_e    sel;
    logic        flush;
    logic [31:0] pc_q;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic [63:0] if_id_q;
    logic [63:0] if_id_d;

    pc_select u_pc_select (
        .pc_if_id_write (bus.PC_IF_ID_Write),
        .z              (bus.Z),
        .j              (bus.J),
        .jr             (bus.JR),
        .interrupt      (bus.interrupt),
        .exception      (bus.exception),
        .sel            (sel),
        .flush          (flush)
    );

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        next_pc = pc_plus4;
        case (sel)
            SEL_IRQ:  next_pc = IRQ_VECTOR;
            SEL_EXC:  next_pc = EXC_VECTOR;
            SEL_HOLD: next_pc = pc_q;
            // JR may drop to user mode but can never raise the supervisor bit.
            SEL_JR:   next_pc = {pc_q[31] & bus.jr_target[31], bus.jr_target[30:0]};
            SEL_J:    next_pc = bus.jump_target;
            SEL_BR:   next_pc = bus.branch_target;
            default:  next_pc = pc_plus4;
        endcase
    end

    // A squashed fetch still carries its PC+4 so ID sees the right PC[31].
    always_comb begin
        if_id_d                    = '0;
        if_id_d[PC4_MSB:PC4_LSB]   = pc_plus4;
        if_id_d[INSTR_MSB:INSTR_LSB] = flush ? NOP_INSTR : bus.imem_rdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_VECTOR;
            if_id_q <= '0;
        end else if (sel != SEL_HOLD) begin
            pc_q    <= next_pc;
            if_id_q <= if_id_d;
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.PC        = pc_q;
    assign bus.IF_ID     = if_id_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (sel == SEL_SEQ) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (flush)          flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign bus.fetch_count = fetch_cnt_q;
    assign bus.flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, counter sequence
// (FETCH_PERF_CNT_EN builds) and randomized run against a reference model.
module tb_fetch_stage;

    logic clk;
    logic rst_n;
    fetch_stage_if bus ();

    fetch_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'h2008_0005 : {a[15:0], ~a[15:0]};
    endfunction

    assign bus.imem_rdata = imem(bus.imem_addr);

    typedef struct {
        logic        rst_n, wr, z, j, jr, irq, exc;
        logic [31:0] bt, jt, jrt;
        logic [31:0] exp_pc;
        logic [63:0] exp_ifid;
    } vec_t;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_pc;
    logic [63:0] m_ifid;
    logic [31:0] m_fetch;
    logic [31:0] m_flush;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model straight from the next-PC priority rules.
    task automatic model(input vec_t v);
        logic [31:0] seq;
        logic [31:0] tgt;
        logic        redirect;
        seq = m_pc + 32'd4;
        redirect = 1'b0;
        tgt = seq;
        if (!v.rst_n) begin
            m_pc = 32'h8000_0000; m_ifid = 64'd0; m_fetch = 0; m_flush = 0;
        end else begin
            if (v.irq || v.exc) begin
                redirect = 1'b1; tgt = v.irq ? 32'h8000_0004 : 32'h8000_0008;
            end else if (v.wr) begin
                if (v.jr) begin
                    redirect = 1'b1; tgt = v.jrt;
                    if (!m_pc[31]) tgt[31] = 1'b0;
                end else if (v.j) begin
                    redirect = 1'b1; tgt = v.jt;
                end else if (v.z) begin
                    redirect = 1'b1; tgt = v.bt;
                end
            end
            if (redirect) begin
                m_ifid = {seq, 32'h0}; m_pc = tgt; m_flush++;
            end else if (v.wr) begin
                m_ifid = {seq, imem(m_pc)}; m_pc = seq; m_fetch++;
            end
        end
    endtask

    task automatic apply(input vec_t v);
        rst_n              = v.rst_n;
        bus.PC_IF_ID_Write = v.wr;
        bus.Z              = v.z;
        bus.J              = v.j;
        bus.JR             = v.jr;
        bus.interrupt      = v.irq;
        bus.exception      = v.exc;
        bus.branch_target  = v.bt;
        bus.jump_target    = v.jt;
        bus.jr_target      = v.jrt;
        @(posedge clk);
        model(v);
        #1;
    endtask

    function automatic vec_t mk(input logic r, wr, z, j, jr, irq, exc,
                                input logic [31:0] bt, jt, jrt, epc,
                                input logic [63:0] eifid);
        vec_t v;
        v.rst_n = r; v.wr = wr; v.z = z; v.j = j; v.jr = jr; v.irq = irq; v.exc = exc;
        v.bt = bt; v.jt = jt; v.jrt = jrt; v.exp_pc = epc; v.exp_ifid = eifid;
        return v;
    endfunction

    vec_t tbl[26];

    initial begin
        vec_t v;
        m_pc = '0; m_ifid = '0; m_fetch = '0; m_flush = '0;
        rst_n = 1'b0;
        bus.PC_IF_ID_Write = 1'b1;
        {bus.Z, bus.J, bus.JR, bus.interrupt, bus.exception} = '0;
        bus.branch_target = '0; bus.jump_target = '0; bus.jr_target = '0;

        //          r wr z j jr i e  bt            jt            jrt           exp_pc
        tbl[0]  = mk(0,1,0,0,0,0,0, 32'h0,        32'h0,        32'h0,        32'h8000_0000, 64'h0);
        tbl[1]  = mk(1,1,0,0,0,0,0, 32'h0,        32'h0,        32'h0,        32'h8000_0004, {32'h8000_0004, 32'h2008_0005});
        tbl[2]  = mk(1,1,0,0,0,0,0, 32'h0,        32'h0,        32'h0,        32'h8000_0008, {32'h8000_0008, imem(32'h8000_0004)});
        tbl[3]  = mk(1,1,0,0,0,0,0, 32'h0,        32'h0,        32'h0,        32'h8000_000C, {32'h8000_000C, imem(32'h8000_0008)});
        tbl[4]  = mk(1,1,0,0,0,0,0, 32'h0,        32'h0,        32'h0,        32'h8000_0010, {32'h8000_0010, imem(32'h8000_000C)});
        tbl[5]  = mk(1,0,0,0,0,0,0, 32'h0,        32'h0,        32'h0,        32'h8000_0010, {32'h8000_0010, imem(32'h8000_000C)});
        tbl[6]  = mk(1,0,0,0,0,0,0, 32'h0,        32'h0,        32'h0,        32'h8000_0010, {32'h8000_0010, imem(32'h8000_000C)});
        tbl[7]  = mk(1,1,0,0,0,0,0, 32'h0,        32'h0,        32'h0,        32'h8000_0014, {32'h8000_0014, imem(32'h8000_0010)});
        tbl[8]  = mk(1,1,0,1,0,0,0, 32'h0,        32'h8000_0020,32'h0,        32'h8000_0020, {32'h8000_0018, 32'h0});
        tbl[9]  = mk(1,1,1,0,0,0,0, 32'h8000_0040,32'h0,        32'h0,        32'h8000_0040, {32'h8000_0024, 32'h0});
        tbl[10] = mk(1,0,1,0,0,0,0, 32'h8000_0080,32'h0,        32'h0,        32'h8000_0040, {32'h8000_0024, 32'h0});
        tbl[11] = mk(1,1,0,1,0,0,0, 32'h0,        32'h8000_0100,32'h0,        32'h8000_0100, {32'h8000_0044, 32'h0});
        tbl[12] = mk(1,1,0,0,1,0,0, 32'h0,        32'h0,        32'h0000_1000,32'h0000_1000, {32'h8000_0104, 32'h0});
        tbl[13] = mk(1,1,0,1,0,0,0, 32'h0,        32'h0000_2000,32'h0,        32'h0000_2000, {32'h0000_1004, 32'h0});
        tbl[14] = mk(1,1,0,0,1,0,0, 32'h0,        32'h0,        32'h8000_0000,32'h0000_0000, {32'h0000_2004, 32'h0});
        tbl[15] = mk(1,1,0,1,0,0,0, 32'h0,        32'h0000_0300,32'h0,        32'h0000_0300, {32'h0000_0004, 32'h0});
        tbl[16] = mk(1,0,0,1,0,1,1, 32'h0,        32'h0000_0500,32'h0,        32'h8000_0004, {32'h0000_0304, 32'h0});
        tbl[17] = mk(1,1,0,0,0,0,1, 32'h0,        32'h0,        32'h0,        32'h8000_0008, {32'h8000_0008, 32'h0});
        tbl[18] = mk(1,1,1,1,0,0,0, 32'h8000_0400,32'h8000_0200,32'h0,        32'h8000_0200, {32'h8000_000C, 32'h0});
        tbl[19] = mk(1,1,0,1,0,0,0, 32'h0,        32'h7FFF_FFFC,32'h0,        32'h7FFF_FFFC, {32'h8000_0204, 32'h0});
        tbl[20] = mk(1,1,0,0,0,0,0, 32'h0,        32'h0,        32'h0,        32'h8000_0000, {32'h8000_0000, imem(32'h7FFF_FFFC)});
        tbl[21] = mk(1,1,0,1,0,0,0, 32'h0,        32'hFFFF_FFFC,32'h0,        32'hFFFF_FFFC, {32'h8000_0004, 32'h0});
        tbl[22] = mk(1,1,0,0,0,0,0, 32'h0,        32'h0,        32'h0,        32'h0000_0000, {32'h0000_0000, imem(32'hFFFF_FFFC)});
        tbl[23] = mk(0,1,0,1,0,0,0, 32'h0,        32'h0000_0700,32'h0,        32'h8000_0000, 64'h0);
        tbl[24] = mk(1,1,0,0,1,0,0, 32'h0,        32'h0,        32'h8000_1003,32'h8000_1003, {32'h8000_0004, 32'h0});
        tbl[25] = mk(1,0,0,0,0,1,0, 32'h0,        32'h0,        32'h0,        32'h8000_0004, {32'h8000_1007, 32'h0});

        for (int i = 0; i < 26; i++) begin
            apply(tbl[i]);
            chk($sformatf("vec%0d_pc", i), {32'h0, bus.PC}, {32'h0, tbl[i].exp_pc});
            chk($sformatf("vec%0d_ifid", i), bus.IF_ID, tbl[i].exp_ifid);
            chk($sformatf("vec%0d_imem_addr", i), {32'h0, bus.imem_addr}, {32'h0, tbl[i].exp_pc});
        end

`ifdef FETCH_PERF_CNT_EN
        apply(mk(0,1,0,0,0,0,0, 0,0,0, 0,0));
        chk("cnt_rst_fetch", {32'h0, bus.fetch_count}, 64'd0);
        chk("cnt_rst_flush", {32'h0, bus.flush_count}, 64'd0);
        for (int i = 0; i < 3; i++) apply(mk(1,1,0,0,0,0,0, 0,0,0, 0,0));
        apply(mk(1,1,0,1,0,0,0, 0,32'h8000_0100,0, 0,0));
        apply(mk(1,0,1,0,0,0,0, 32'h8000_0300,0,0, 0,0));
        chk("cnt_fetch3", {32'h0, bus.fetch_count}, 64'd3);
        chk("cnt_flush1", {32'h0, bus.flush_count}, 64'd1);
`endif

        for (int i = 0; i < 400; i++) begin
            v.rst_n = ($urandom_range(0, 39) != 0);
            v.wr    = ($urandom_range(0, 4) != 0);
            v.z     = ($urandom_range(0, 5) == 0);
            v.j     = ($urandom_range(0, 7) == 0);
            v.jr    = ($urandom_range(0, 7) == 0);
            v.irq   = ($urandom_range(0, 19) == 0);
            v.exc   = ($urandom_range(0, 19) == 0);
            v.bt    = $urandom;
            v.jt    = $urandom;
            v.jrt   = $urandom;
            v.exp_pc = '0; v.exp_ifid = '0;
            apply(v);
            chk($sformatf("rnd%0d_pc", i), {32'h0, bus.PC}, {32'h0, m_pc});
            chk($sformatf("rnd%0d_ifid", i), bus.IF_ID, m_ifid);
`ifdef FETCH_PERF_CNT_EN
            chk($sformatf("rnd%0d_fetch_cnt", i), {32'h0, bus.fetch_count}, {32'h0, m_fetch});
            chk($sformatf("rnd%0d_flush_cnt", i), {32'h0, bus.flush_count}, {32'h0, m_flush});
`endif
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
